// File: rtl/demux4_buf_if.sv
// demux4_buf_if
// Handshake bundle for the 1-to-4 buffered demultiplexer.
//   in_valid/in_ready/in_sel/in_data : upstream beat and its destination lane
//   out_valid/out_ready              : per-lane handshake, bit N belongs to lane N
//   out_data0..out_data3             : per-lane payload
// Modports:
//   slave  : the demultiplexer's view (takes the beat, drives the lanes)
//   master : the surrounding logic's view (drives the beat, consumes the lanes)
interface demux4_buf_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux4_buf.sv
// demux4_buf
// Registered 1-to-4 demultiplexer. One WIDTH-bit input stream is routed per
// beat to one of four lanes chosen by in_sel. Every lane owns a one-entry
// buffer, so a stalled consumer only blocks beats addressed to its own lane.
// Ports:
//   clk      : single clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset; clears full flags and lane data
//   flush    : synchronous clear of all lane buffers; blocks input that cycle
//   bus      : demux4_buf_if.slave handshake bundle (input beat + four lanes)
//   busy     : OR of all lane valids
// Configuration:
//   DEMUX4_BYPASS_EN : when defined, a beat for an empty lane whose consumer
//                      is ready passes straight through in the same cycle and
//                      leaves the buffer empty. When undefined, every output
//                      is a pure register output with one cycle of latency.
module demux4_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  demux4_buf_if.slave bus,
  output logic        busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  lane_state_e      state_q [4];
  lane_state_e      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];

  logic [3:0] full;
  logic [3:0] hit;
  logic [3:0] byp;
  logic [3:0] load;
  logic [3:0] drain;
  logic [3:0] out_valid_c;
  logic       in_ready_c;

  always_comb begin
    full = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      full[i] = (state_q[i] == FULL);
    end
  end

  // Readiness is taken from the buffer occupancy, not from out_valid, so the
  // bypass path cannot close a loop from in_ready back onto itself.
  assign in_ready_c = !flush && (!full[bus.in_sel] || bus.out_ready[bus.in_sel]);

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      hit[i] = bus.in_valid && in_ready_c && (bus.in_sel == 2'(i));
    end
  end

`ifdef DEMUX4_BYPASS_EN
  assign byp = hit & ~full & bus.out_ready;
`else
  assign byp = '0;
`endif

  assign load  = hit & ~byp;
  assign drain = full & bus.out_ready;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      if (flush) begin
        state_d[i] = EMPTY;
      end else if (load[i]) begin
        // A load on a draining lane replaces the old beat on the same edge.
        state_d[i] = FULL;
        data_d[i]  = bus.in_data;
      end else if (drain[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign out_valid_c   = full | byp;
  assign bus.out_valid = out_valid_c;
  assign bus.in_ready  = in_ready_c;
  assign busy          = |out_valid_c;

`ifdef DEMUX4_BYPASS_EN
  assign bus.out_data0 = byp[0] ? bus.in_data : data_q[0];
  assign bus.out_data1 = byp[1] ? bus.in_data : data_q[1];
  assign bus.out_data2 = byp[2] ? bus.in_data : data_q[2];
  assign bus.out_data3 = byp[3] ? bus.in_data : data_q[3];
`else
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
`endif

endmodule
